eeprom_cmd_seq: RTL and testbench
=================================

// Module: eeprom_cmd_seq
// PURPOSE
//  Command sequencer directly upstream of the I2C EEPROM read/write controller.
//  Accepts single-byte read/write requests on a valid/ready interface and drives the controller's WR/RD/ADDR/DATA pins.
//  Waits for the controller's ACK, captures read data and returns one response per command.
//  Enforces the EEPROM write-cycle recovery time and a no-ACK timeout.
// PARAMETERS
//  TIMEOUT_CYC  4096   max CLK cycles in WAIT_ACK before aborting the command with rsp_err=1
//  WR_WAIT_CYC  10000  CLK cycles of recovery after a write ACK before the response is issued
// PORTS
//  CLK        in   1   single clock; all logic on posedge
//  RESET      in   1   asynchronous, active-low reset
//  cmd_valid  in   1   request present
//  cmd_ready  out  1   sequencer can accept a request; 1 only in IDLE
//  cmd_rw     in   1   1 = read, 0 = write
//  cmd_addr   in   11  EEPROM byte address
//  cmd_wdata  in   8   write data; ignored for reads
//  rsp_valid  out  1   response present; held until rsp_ready
//  rsp_ready  in   1   response consumer ready
//  rsp_rdata  out  8   read data; 8'h00 for writes and errors
//  rsp_err    out  1   1 = ACK timeout
//  busy       out  1   1 in any state other than IDLE
//  WR         out  1   write strobe to controller
//  RD         out  1   read strobe to controller
//  ADDR       out  11  address to controller
//  DATA       inout 8  driven with write data during write commands; high-Z otherwise
//  ACK        in   1   controller end-of-transfer indication
// BEHAVIOUR
//  Reset (RESET=0, async) values:
//   - state=IDLE, WR=0, RD=0, ADDR=0, DATA=Z.
//   - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, cmd_ready=1.
//   - Timeout and recovery counters cleared.
//  FSM states: IDLE -> ISSUE -> WAIT_ACK -> (WR_RECOVER) -> RESP -> IDLE.
//  IDLE:
//   - cmd_ready=1.
//   - When cmd_valid=1, latch rw/addr/wdata, drive ADDR, and go to ISSUE.
//  ISSUE:
//   - Exactly one cycle. WR=1 (write) or RD=1 (read); never both.
//   - Go to WAIT_ACK and clear the timeout counter.
//  WAIT_ACK:
//   - WR=RD=0. ADDR stays stable; for writes DATA stays driven with the latched wdata.
//   - When ACK=1:
//     - Read: capture DATA into rsp_rdata in the same cycle, then go to RESP.
//     - Write: go to WR_RECOVER.
//   - If the counter reaches TIMEOUT_CYC-1 with ACK=0: rsp_err=1, rsp_rdata=0, go to RESP.
//   - ACK takes priority over timeout when both occur in the same cycle.
//  WR_RECOVER:
//   - Count WR_WAIT_CYC cycles, then go to RESP.
//   - DATA is released on entry to this state. ACK is ignored.
//  RESP:
//   - rsp_valid=1, with rsp_* stable.
//   - When rsp_ready=1, deassert rsp_valid and go to IDLE.
//   - The next command can be accepted no earlier than the cycle after the handshake.
//  General rules:
//   - ACK outside WAIT_ACK is ignored.
//   - DATA is never driven while rw=1 or while in IDLE.
//   - Latency, read with no stalls: accept(T), RD pulse (T+1), ACK at T+k, rsp_valid at T+k+1.
//   - Latency, write: rsp_valid at T+k+1+WR_WAIT_CYC.
//   - Counters are sized with $clog2(param+1) and are saturation-free, because they are cleared on each state entry.
//   - Reset mid-command: immediate return to reset values and release of DATA.
//     - The partially issued command is dropped and no response is produced.
// TESTING
//  (bench: TIMEOUT_CYC=32, WR_WAIT_CYC=8; controller model ACKs N cycles after a strobe)
//  1. Write: addr=11'h155, wdata=8'hA5, ACK after 20 cycles.
//     -> one WR pulse; DATA=A5 held until ACK; rsp_valid 9 cycles after ACK; rsp_err=0.
//  2. Read: addr=11'h7FF, model drives DATA=8'h3C with ACK.
//     -> one RD pulse; DATA never driven by the DUT; rsp_rdata=3C; rsp_err=0.
//  3. Timeout: read with no ACK.
//     -> rsp_valid 32 cycles after entering WAIT_ACK; rsp_err=1; rsp_rdata=00.
//  4. Back-pressure: rsp_ready=0 for 10 cycles, with cmd_valid held high.
//     -> rsp_* stable; cmd_ready=0 throughout; the next command is accepted 1 cycle after the handshake.
//  5. Spurious ACK pulses in IDLE and WR_RECOVER.
//     -> no state change, no response, recovery count unchanged.
//  6. RESET pulled low during WAIT_ACK of a write.
//     -> DATA=Z and WR/RD=0 immediately; after release busy=0 and cmd_ready=1, with no response.

Source files
------------

// File: rtl/eeprom_cmd_seq_if.sv
// -----------------------------------------------------------------------------
// eeprom_cmd_seq_if
//   Request/response handshake bundle between a command producer and the
//   EEPROM command sequencer.
//
//   cmd_valid  producer -> seq  request present
//   cmd_ready  seq -> producer  sequencer can take a request
//   cmd_rw     producer -> seq  1 = read, 0 = write
//   cmd_addr   producer -> seq  11-bit EEPROM byte address
//   cmd_wdata  producer -> seq  write data (ignored for reads)
//   rsp_valid  seq -> producer  response present, held until rsp_ready
//   rsp_ready  producer -> seq  producer can take the response
//   rsp_rdata  seq -> producer  read data, 8'h00 for writes and errors
//   rsp_err    seq -> producer  1 = controller never acknowledged
//
//   master = command producer, slave = sequencer.
// -----------------------------------------------------------------------------
interface eeprom_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/eeprom_cmd_seq.sv
// -----------------------------------------------------------------------------
// eeprom_cmd_seq
//   Command sequencer in front of an I2C EEPROM read/write controller.
//   Takes one single-byte read or write request at a time, strobes the
//   controller, waits for its ACK (bounded by TIMEOUT_CYC), holds off the
//   response of a write for WR_WAIT_CYC cycles of EEPROM write-cycle recovery,
//   and returns exactly one response per accepted command.
//
// Parameters
//   TIMEOUT_CYC  cycles allowed in WAIT_ACK before the command aborts (rsp_err)
//   WR_WAIT_CYC  recovery cycles after a write ACK before the response
//
// Ports
//   CLK     single clock, all logic on posedge
//   RESET   asynchronous active-low reset
//   bus     request/response handshake (slave side)
//   busy    1 whenever not idle
//   WR, RD  one-cycle write/read strobes to the controller
//   ADDR    latched command address to the controller
//   DATA    bidirectional controller data: driven with write data from the
//           strobe until the ACK of a write, released otherwise; sampled as
//           read data on the ACK of a read
//   ACK     controller end-of-transfer indication
// -----------------------------------------------------------------------------
module eeprom_cmd_seq #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned WR_WAIT_CYC = 10000
) (
  input  logic              CLK,
  input  logic              RESET,
  eeprom_cmd_seq_if.slave   bus,
  output logic              busy,
  output logic              WR,
  output logic              RD,
  output logic [10:0]       ADDR,
  inout  wire  [7:0]        DATA,
  input  logic              ACK
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned REC_W = $clog2(WR_WAIT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WR_RECOVER,
    S_RESP
  } state_t;

  state_t             state_q;
  state_t             state_d;

  // Latched command and response registers.
  logic               rw_q;
  logic [10:0]        addr_q;
  logic [7:0]         wdata_q;
  logic [7:0]         rdata_q;
  logic               err_q;

  // Both counters restart on entry to the state that uses them, so they never
  // need to saturate: each state leaves at its terminal count.
  logic [TO_W-1:0]    to_cnt;
  logic [REC_W-1:0]   rec_cnt;
  logic               to_last;
  logic               rec_last;

  logic               data_oe;

  assign to_last  = (to_cnt  == TO_W'(TIMEOUT_CYC - 1));
  assign rec_last = (rec_cnt == REC_W'(WR_WAIT_CYC - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked processes use non-blocking (<=) so every register samples
  // the pre-edge value of every other register, independent of process order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (bus.cmd_valid) state_d = S_ISSUE;
      S_ISSUE:      state_d = S_WAIT_ACK;
      // ACK is tested first so it wins over a timeout in the same cycle.
      S_WAIT_ACK: begin
        if (ACK)          state_d = rw_q ? S_RESP : S_WR_RECOVER;
        else if (to_last) state_d = S_RESP;
      end
      S_WR_RECOVER: if (rec_last) state_d = S_RESP;
      S_RESP:       if (bus.rsp_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore: depends on state and latched direction only)
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case; a path that skipped an
  // assignment would otherwise infer a latch.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    WR            = 1'b0;
    RD            = 1'b0;
    data_oe       = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      S_ISSUE: begin
        WR      = ~rw_q;
        RD      =  rw_q;
        data_oe = ~rw_q;
      end
      S_WAIT_ACK: data_oe = ~rw_q;
      S_RESP:     bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Released in IDLE and for reads; asynchronous reset returns the FSM to
  // IDLE, which releases the bus without waiting for a clock.
  assign DATA = data_oe ? wdata_q : 8'hzz;

  assign ADDR          = addr_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // ---------------------------------------------------------------------------
  // Command latch, response capture and cycle counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_cnt  <= '0;
      rec_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            rw_q    <= bus.cmd_rw;
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            // Clear the previous response so writes report 8'h00 / no error.
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        S_ISSUE: to_cnt <= '0;
        S_WAIT_ACK: begin
          if (ACK) begin
            if (rw_q) rdata_q <= DATA;
            else      rec_cnt <= '0;
          end else if (to_last) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WR_RECOVER: rec_cnt <= rec_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_eeprom_cmd_seq
//   Drives eeprom_cmd_seq with directed and random commands against a small
//   EEPROM controller model. Expected responses and timing come from the
//   command rules: a read returns the last acknowledged write to that address
//   (or the initial contents), an unacknowledged command errors after the
//   timeout window, and a write response waits out the recovery time.
// -----------------------------------------------------------------------------
module tb_eeprom_cmd_seq;

  localparam int TO = 32;
  localparam int WW = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        busy;
  logic        WR;
  logic        RD;
  logic [10:0] ADDR;
  logic        ACK = 1'b0;
  tri1  [7:0]  data_bus;
  logic        model_oe = 1'b0;
  logic [7:0]  model_data = 8'h00;

  eeprom_cmd_seq_if bus ();

  assign data_bus = model_oe ? model_data : 8'hzz;

  eeprom_cmd_seq #(.TIMEOUT_CYC(TO), .WR_WAIT_CYC(WW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .busy  (busy),
    .WR    (WR),
    .RD    (RD),
    .ADDR  (ADDR),
    .DATA  (data_bus),
    .ACK   (ACK)
  );

  always #5 CLK = ~CLK;

  // Controller-side storage and the independently tracked expectation.
  logic [7:0] model_mem [2048];
  logic [7:0] exp_mem   [2048];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete command. Called with the DUT idle; returns 1 ns after the
  // response handshake edge. k = ACK delay in cycles after accept (cycle T+k),
  // 0 = controller never acknowledges.
  task automatic run_cmd(input bit rw, input logic [10:0] addr, input logic [7:0] wdata,
                         input int k, input int stall, input bit spur, input bit hold);
    int         n, exp_n, drive_end, strobes, strobe_n;
    int         bad_type, bad_addr, bad_bus, bad_busy, bad_stall;
    bit         got;
    logic [7:0] exp_rdata, exp_bus;
    bit         exp_err;

    n = 0; strobes = 0; strobe_n = -1; got = 0;
    bad_type = 0; bad_addr = 0; bad_bus = 0; bad_busy = 0; bad_stall = 0;

    if (k == 0) begin
      exp_n = TO + 1; exp_err = 1'b1; exp_rdata = 8'h00; drive_end = TO + 1;
    end else begin
      exp_n = rw ? k : k + WW; exp_err = 1'b0; drive_end = k;
      exp_rdata = rw ? exp_mem[addr] : 8'h00;
    end

    check("idle_ready", bus.cmd_ready, 1);
    check("idle_busy", busy, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    @(posedge CLK);
    #1;
    if (!hold) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_rw    = 1'($urandom);
      bus.cmd_addr  = 11'($urandom);
      bus.cmd_wdata = 8'($urandom);
    end

    while (!got && n <= exp_n + 40) begin
      @(negedge CLK);
      ACK = 1'b0;
      model_oe = 1'b0;
      #1;
      if (WR || RD) begin
        strobes++;
        if (strobe_n < 0) strobe_n = n;
      end
      if ((WR && RD) || (rw && WR) || (!rw && RD)) bad_type++;
      if (ADDR !== addr) bad_addr++;
      exp_bus = (!rw && n < drive_end) ? wdata : 8'hFF;
      if (data_bus !== exp_bus) bad_bus++;
      if (bus.rsp_valid) begin
        got = 1;
      end else begin
        if (bus.cmd_ready !== 1'b0 || busy !== 1'b1) bad_busy++;
        if (k != 0 && n + 1 == k) begin
          ACK = 1'b1;
          if (rw) begin
            model_oe   = 1'b1;
            model_data = model_mem[ADDR];
          end else begin
            model_mem[ADDR] = data_bus;
          end
        end else if (spur && !rw && k != 0 && n == k + 3) begin
          ACK = 1'b1;
        end
        n++;
      end
    end

    check("rsp_seen", got, 1);
    check("rsp_latency", n, exp_n);
    check("strobe_count", strobes, 1);
    check("strobe_pos", strobe_n, 0);
    check("strobe_type", bad_type, 0);
    check("addr_stable", bad_addr, 0);
    check("data_bus", bad_bus, 0);
    check("busy_ready", bad_busy, 0);
    check("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check("rsp_err", bus.rsp_err, exp_err);

    for (int i = 0; i < stall; i++) begin
      @(negedge CLK);
      #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_rdata ||
          bus.rsp_err !== exp_err || bus.cmd_ready !== 1'b0) bad_stall++;
    end
    check("rsp_hold", bad_stall, 0);

    bus.rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_drop", bus.rsp_valid, 0);

    if (!rw && k != 0) exp_mem[addr] = wdata;
  endtask

  // Random ACK pulses while idle: nothing may happen.
  task automatic idle_spurious(input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      ACK = 1'b0;
      #1;
      if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || WR !== 1'b0 || RD !== 1'b0 ||
          data_bus !== 8'hFF) bad++;
      ACK = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    ACK = 1'b0;
    #1;
    check("idle_spurious", bad, 0);
  endtask

  task automatic reset_mid_write();
    int bad;
    bad = 0;
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = 11'h2AA;
    bus.cmd_wdata = 8'h5A;
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge CLK);
    #1;
    check("pre_rst_data", data_bus, 8'h5A);
    check("pre_rst_busy", busy, 1);
    #2;
    RESET = 1'b0;
    #1;
    check("rst_data_z", data_bus, 8'hFF);
    check("rst_strobes", {WR, RD}, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 10'h000);
    check("rst_addr", ADDR, 11'h000);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < TO + WW + 10; i++) begin
      @(negedge CLK);
      #1;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) bad++;
    end
    check("post_rst_quiet", bad, 0);
  endtask

  initial begin
    logic [10:0] pool [4];
    bit          rw;
    logic [10:0] addr;
    int          sel, k;

    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    for (int i = 0; i < 2048; i++) begin
      model_mem[i] = 8'($urandom);
      exp_mem[i]   = model_mem[i];
    end
    model_mem[11'h7FF] = 8'h3C;
    exp_mem[11'h7FF]   = 8'h3C;

    // Reset values
    #1;
    check("reset_ready", bus.cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_strobes", {WR, RD}, 2'b00);
    check("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 10'h000);
    check("reset_data_z", data_bus, 8'hFF);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    #1;

    // Directed cases
    run_cmd(1'b0, 11'h155, 8'hA5, 20, 0, 1'b0, 1'b0);   // write
    run_cmd(1'b1, 11'h7FF, 8'h00, 5, 0, 1'b0, 1'b0);    // read, 3C
    run_cmd(1'b1, 11'h155, 8'h00, 2, 0, 1'b0, 1'b0);    // read back A5
    run_cmd(1'b1, 11'h123, 8'h00, 0, 0, 1'b0, 1'b0);    // timeout
    run_cmd(1'b1, 11'h155, 8'h00, 7, 10, 1'b0, 1'b1);   // back-pressure, valid held
    run_cmd(1'b0, 11'h000, 8'h11, 2, 0, 1'b0, 1'b0);    // accepted right after
    run_cmd(1'b1, 11'h000, 8'h00, 33, 0, 1'b0, 1'b0);   // ACK on timeout cycle
    idle_spurious(8);
    run_cmd(1'b0, 11'h003, 8'h42, 6, 0, 1'b1, 1'b0);    // spurious ACK in recovery
    idle_spurious(4);
    reset_mid_write();

    // Random traffic
    pool[0] = 11'h000; pool[1] = 11'h003; pool[2] = 11'h155; pool[3] = 11'h7FF;
    for (int t = 0; t < 40; t++) begin
      rw   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 11'($urandom) : pool[$urandom_range(0, 3)];
      sel  = $urandom_range(0, 7);
      k    = (sel == 0) ? 0 : (sel == 1) ? 33 : (sel == 2) ? 2 : $urandom_range(2, 33);
      run_cmd(rw, addr, 8'($urandom_range(0, 254)), k, $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.cmd_valid = 1'b0;
    idle_spurious(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
